// File: rtl/exe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package     : exe_pkg                                              |
// | Description : Shared types for the execute-stage mul/div unit.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package exe_pkg;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : muldiv_sign_fix                                      |
// | Description : Operand magnitude extraction at accept and final     |
// |               sign correction / result selection at completion.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module muldiv_sign_fix
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  // operand side
  input  muldiv_op_e          op,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  output logic [XLEN-1:0]     a_mag,
  output logic [XLEN-1:0]     b_mag,
  output logic                neg_q,
  output logic                neg_r,
  // result side
  input  muldiv_op_e          res_op,
  input  logic                res_neg_q,
  input  logic                res_neg_r,
  input  logic [2*XLEN-1:0]   prod,
  input  logic [XLEN-1:0]     quo,
  input  logic [XLEN-1:0]     rem,
  output logic [XLEN-1:0]     result
);

  logic            s1_signed, s2_signed, neg1, neg2;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo_s, rem_s;

  // MUL is treated as signed: the low half is identical either way
  assign s1_signed = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign s2_signed = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign neg1      = s1_signed & rs1[XLEN-1];
  assign neg2      = s2_signed & rs2[XLEN-1];
  assign a_mag     = neg1 ? -rs1 : rs1;
  assign b_mag     = neg2 ? -rs2 : rs2;
  assign neg_q     = neg1 ^ neg2;
  assign neg_r     = neg1;

  assign prod_s = res_neg_q ? -prod : prod;
  assign quo_s  = res_neg_q ? -quo  : quo;
  assign rem_s  = res_neg_r ? -rem  : rem;

  // Select the architectural result for the latched operation
  always_comb begin
    result = '0;
    case (res_op)
      OP_MUL:                       result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_s;
      default:                      result = rem_s;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : exe_muldiv_unit                                      |
// | Description : Iterative RV32M multiply/divide engine with          |
// |               valid/ready handshake, pipeline stall and flush.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module exe_muldiv_unit
  import exe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_rd
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  muldiv_op_e       op_q, req_op_e;
  logic             neg_q, neg_r;
  logic [XLEN:0]    acc;          // product high half / partial remainder
  logic [XLEN-1:0]  lo;           // product low half / dividend-quotient
  logic [XLEN-1:0]  dvs;          // multiplicand / divisor magnitude

  logic [XLEN-1:0]  a_mag, b_mag, result, special_val;
  logic             in_neg_q, in_neg_r, accept, is_special, div_zero, div_ovf;
  logic [XLEN:0]    mul_sum, div_shift, div_diff, acc_nxt;
  logic [XLEN-1:0]  lo_nxt;

  assign req_op_e = muldiv_op_e'(req_op);
  assign accept   = (state == IDLE) && req_valid && !flush;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op        (req_op_e),
    .rs1       (req_rs1),
    .rs2       (req_rs2),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .neg_q     (in_neg_q),
    .neg_r     (in_neg_r),
    .res_op    (op_q),
    .res_neg_q (neg_q),
    .res_neg_r (neg_r),
    .prod      ({acc_nxt[XLEN-1:0], lo_nxt}),
    .quo       (lo_nxt),
    .rem       (acc_nxt[XLEN-1:0]),
    .result    (result)
  );

  // Divide corner cases resolved at accept without iterating
  always_comb begin
    div_zero    = is_div(req_op_e) && (req_rs2 == '0);
    div_ovf     = (req_op_e inside {OP_DIV, OP_REM}) &&
                  (req_rs1 == INT_MIN) && (req_rs2 == '1);
    is_special  = div_zero || div_ovf;
    special_val = '0;
    if (div_zero)
      special_val = req_op[1] ? req_rs1 : '1;
    else if (div_ovf)
      special_val = req_op[1] ? '0 : req_rs1;
  end

  // One radix-2 step: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum   = acc + (lo[0] ? {1'b0, dvs} : '0);
    div_shift = {acc[XLEN-1:0], lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvs};
    acc_nxt   = {1'b0, mul_sum[XLEN:1]};
    lo_nxt    = {mul_sum[0], lo[XLEN-1:1]};
    if (is_div(op_q)) begin
      if (!div_diff[XLEN]) begin
        acc_nxt = div_diff;
        lo_nxt  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = div_shift;
        lo_nxt  = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs; flush overrides everything
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    stall_req  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        stall_req = req_valid && !flush;
        if (accept) state_nxt = is_special ? DONE : CALC;
      end
      CALC: begin
        stall_req = 1'b1;
        if (flush)            state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        stall_req  = !resp_ready;
        if (flush || resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      acc       <= '0;
      lo        <= '0;
      dvs       <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(XLEN - 1);
      op_q    <= req_op_e;
      neg_q   <= in_neg_q;
      neg_r   <= in_neg_r;
      acc     <= '0;
      lo      <= a_mag;
      dvs     <= b_mag;
      resp_rd <= req_rd;
      if (is_special) resp_data <= special_val;
    end else if (state == CALC && !flush) begin
      acc <= acc_nxt;
      lo  <= lo_nxt;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) resp_data <= result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_exe_muldiv_unit                                   |
// | Description : Directed self-checking bench for exe_muldiv_unit.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        stall_req;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  int n_checks = 0;
  int n_fails  = 0;

  exe_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .busy       (busy),
    .stall_req  (stall_req),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE (called at a negedge) and check its response.
  // hold > 0 keeps resp_ready low for that many DONE cycles.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int   lat;
    logic stall_ok;
    req_valid  = 1'b1;
    req_op     = op;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
    resp_ready = (hold == 0);
    #1;
    check({name, "_stall_at_req"}, stall_req, 1);
    check({name, "_req_ready"}, req_ready, 1);
    lat      = 0;
    stall_ok = 1'b1;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      req_valid = 1'b0;
      if (!resp_valid && !stall_req) stall_ok = 1'b0;
    end while (!resp_valid && lat < 100);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_stall_busy"}, stall_ok, 1);
    check({name, "_data"}, resp_data, exp);
    check({name, "_rd"}, resp_rd, rd);
    for (int i = 0; i < hold; i++) begin
      check({name, "_held_valid"}, resp_valid, 1);
      check({name, "_held_data"}, resp_data, exp);
      check({name, "_held_stall"}, stall_req, 1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check({name, "_stall_done"}, stall_req, 0);
    @(negedge clk);
    check({name, "_idle_after"}, busy, 0);
    check({name, "_valid_after"}, resp_valid, 0);
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_stall", stall_req, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_rd", resp_rd, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Iterative multiply / divide
    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33, 0);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 33, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, 33, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 33, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 33, 0);
    run_op("divu",   3'd5, 32'd100,        32'd7,         5'd9,  32'd14,        33, 0);
    run_op("remu",   3'd7, 32'd100,        32'd7,         5'd10, 32'd2,         33, 0);

    // Special-case divides finish in one cycle
    run_op("divu_by0", 3'd5, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_by0",  3'd6, 32'd5,         32'd0,         5'd12, 32'd5,         1, 0);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1, 0);

    // Flush in the 10th CALC cycle
    req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd3; req_rs2 = 32'd4; req_rd = 5'd15;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    check("flush_in_calc", busy, 1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", busy, 0);
    check("flush_req_ready", req_ready, 1);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (resp_valid) seen = 1'b1;
        @(negedge clk);
      end
      check("flush_no_resp", seen, 0);
    end
    run_op("divu_after_flush", 3'd5, 32'd9, 32'd3, 5'd16, 32'd3, 33, 0);

    // Backpressure: five cycles of resp_ready low in DONE
    run_op("bp_divu", 3'd5, 32'd100, 32'd7, 5'd17, 32'd14, 33, 5);

    // Asynchronous reset in the middle of CALC
    req_valid = 1'b1; req_op = 3'd4; req_rs1 = 32'd50; req_rs2 = 32'd5; req_rd = 5'd18;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_stall", stall_req, 0);
    check("arst_resp_valid", resp_valid, 0);
    check("arst_resp_data", resp_data, 0);
    check("arst_resp_rd", resp_rd, 0);
    @(negedge clk);
    rst = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (resp_valid || busy) seen = 1'b1;
      end
      check("arst_nothing_after", seen, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
Parametrised iterative RV32M multiply/divide unit attached beside the integer ALU in the execute stage. Operands arrive already forwarded. The unit runs as a multi-cycle engine with a valid/ready request and response handshake. It raises stall_req while it owns the pipeline, and it aborts on a branch-mispredict flush.

Parameters:
XLEN, 32, operand/result width (power of two, >=8)
TAG_W, 5, destination register tag width
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, localparam)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  operation request
req_ready  output  1  unit can accept request
req_op  input  3  funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
req_rs1  input  XLEN  forwarded rs1 operand
req_rs2  input  XLEN  forwarded rs2 operand
req_rd  input  TAG_W  destination tag
flush  input  1  mispredict flush, aborts in-flight op
busy  output  1  state != IDLE
stall_req  output  1  hold upstream stages
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_data  output  XLEN  result
resp_rd  output  TAG_W  tag of result

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, all datapath regs 0; outputs req_ready=1, busy=0, stall_req=0, resp_valid=0, resp_data=0, resp_rd=0.
- States: IDLE, CALC, DONE.
- IDLE: req_ready=1. Accept when req_valid && !flush.
  - Accept of a normal op -> CALC with counter=XLEN-1.
  - Accept of a special-case divide -> DONE directly.
  - Operand magnitudes, sign flags, op and tag are latched at accept.
- Special cases (result in cycle after accept):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones): DIV -> rs1, REM -> 0.
- CALC: one iteration per cycle, exactly XLEN cycles. Counter decrements; leaves CALC when counter==0, latching the sign-corrected result into resp_data -> DONE.
  - Multiply: radix-2 shift-add on magnitudes into a 2*XLEN product register.
    - MUL returns the low half.
    - MULH/MULHSU/MULHU return the high half.
    - Signedness: MULH both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
    - Negate the 2*XLEN product when sign flags differ.
  - Divide: radix-2 restoring, remainder register XLEN+1 bits.
    - Quotient sign = sign(rs1) XOR sign(rs2).
    - Remainder sign = sign(rs1) (signed ops only).
- DONE: resp_valid=1, with resp_data/resp_rd stable. Leave to IDLE on resp_ready; no new accept in that same cycle.
- Latency: accept in cycle N -> resp_valid in cycle N+XLEN+1 for normal ops, N+1 for special cases.
- stall_req = (state==CALC) || (state==DONE && !resp_ready). It is also asserted in IDLE when req_valid && !flush.
- flush: in any state, next state=IDLE and resp_valid drops next cycle; the in-flight result is discarded. Flush has priority over accept and over resp_ready.
- resp_valid is never asserted without a preceding accept. Backpressure holds DONE indefinitely.
- Reset asserted mid-CALC or mid-DONE returns to reset values immediately; nothing is emitted after release.

Decomposition:
- Shared package exe_pkg:
  - muldiv_op_e enum (8 funct3 encodings)
  - muldiv_state_e {IDLE, CALC, DONE}
  - helper function is_div(op)
- One sub-module, muldiv_sign_fix: combinational operand-magnitude and result-negation logic, used at latch and completion.
- Iteration datapath and FSM stay in exe_muldiv_unit.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD (-3), resp_ready=1 -> resp_data=0xFFFFFFEB in cycle N+33, resp_rd echoed, stall_req high cycles N..N+32.
- MULH: 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV/REM: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases (each resp_valid in N+1): DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush at 10th CALC cycle -> IDLE next cycle, no resp_valid, req_ready=1. A new DIVU 9/3 then returns 3.
- Backpressure: resp_ready low 5 cycles in DONE -> resp_data held, stall_req high, then IDLE after handshake. rst pulsed low mid-CALC -> all outputs at reset values asynchronously.
